// File: rtl/pwm_duty_meas.sv
// PWM receiver: measures period and high time of an incoming PWM line,
// reports duty as a fraction of 128 and flags a line stuck high or low.
module pwm_duty_meas #(
    parameter int CNT_W   = 13,
    parameter int TIMEOUT = 8000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_pwm,
    output logic [6:0]       o_duty,
    output logic [CNT_W-1:0] o_period,
    output logic             o_valid,
    output logic             o_stuck,
    output logic             o_drop
);

    localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        SEEK,
        HIGH,
        LOW
    } state_t;

    state_t state_q;
    state_t state_d;

    logic s1;
    logic s2;
    logic s3;
    logic rise;
    logic fall;

    logic [CNT_W-1:0] p;
    logic [CNT_W-1:0] p_nx;
    logic [CNT_W-1:0] hi;

    logic [CNT_W-1:0] r;
    logic [CNT_W-1:0] d;
    logic [6:0]       q;
    logic [2:0]       cnt;
    logic             busy;

    logic [CNT_W:0]   r2;
    logic             ge;
    logic [CNT_W-1:0] r_nx;
    logic [6:0]       q_nx;

    logic tmo;
    logic start;
    logic drop;

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // one restoring-division step; r < d always holds, so r_nx fits CNT_W
    always_comb begin
        r2   = {r, 1'b0};
        ge   = (r2 >= {1'b0, d});
        r_nx = ge ? CNT_W'(r2 - {1'b0, d}) : r2[CNT_W-1:0];
        q_nx = {q[5:0], ge};
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        drop    = 1'b0;
        tmo     = i_en && !rise && !fall && (p == TMO_M1);
        if (!i_en || tmo) begin
            state_d = SEEK;
        end else begin
            unique case (state_q)
                SEEK: if (rise) state_d = HIGH;
                HIGH: if (fall) state_d = LOW;
                LOW: begin
                    if (rise) begin
                        state_d = HIGH;
                        start   = !busy;
                        drop    = busy;
                    end
                end
                default: state_d = SEEK;
            endcase
        end
    end

    // timer counts the whole period in HIGH/LOW, time since last edge in SEEK
    always_comb begin
        if (!i_en) begin
            p_nx = '0;
        end else if (rise) begin
            p_nx = CNT_W'(1);
        end else if (fall && state_q == SEEK) begin
            p_nx = '0;
        end else if (p == TMO) begin
            p_nx = p;
        end else begin
            p_nx = p + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            state_q  <= SEEK;
            p        <= '0;
            hi       <= '0;
            r        <= '0;
            d        <= '0;
            q        <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            o_duty   <= '0;
            o_period <= '0;
            o_valid  <= 1'b0;
            o_stuck  <= 1'b0;
            o_drop   <= 1'b0;
        end else begin
            s1      <= i_pwm;
            s2      <= s1;
            s3      <= s2;
            state_q <= state_d;
            p       <= p_nx;
            o_valid <= 1'b0;
            o_drop  <= drop;
            if (i_en && state_q == HIGH && fall) begin
                hi <= p;
            end
            if (!i_en || tmo) begin
                busy <= 1'b0;
                if (tmo) begin
                    o_duty   <= s2 ? 7'd127 : 7'd0;
                    o_period <= '0;
                    o_stuck  <= 1'b1;
                    o_valid  <= 1'b1;
                end
            end else if (start) begin
                r    <= hi;
                d    <= p;
                q    <= '0;
                cnt  <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                r   <= r_nx;
                q   <= q_nx;
                cnt <= cnt + 3'd1;
                if (cnt == 3'd6) begin
                    busy     <= 1'b0;
                    o_duty   <= q_nx;
                    o_period <= d;
                    o_stuck  <= 1'b0;
                    o_valid  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_meas.sv
// Scoreboard bench for pwm_duty_meas: directed PWM waveforms, expected
// results queued at stimulus time and checked by an independent monitor.
module tb_pwm_duty_meas;

    logic        i_clk;
    logic        i_rst;
    logic        i_en;
    logic        i_pwm;
    logic [6:0]  o_duty;
    logic [12:0] o_period;
    logic        o_valid;
    logic        o_stuck;
    logic        o_drop;

    pwm_duty_meas #(
        .CNT_W  (13),
        .TIMEOUT(8000)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (i_en),
        .i_pwm   (i_pwm),
        .o_duty  (o_duty),
        .o_period(o_period),
        .o_valid (o_valid),
        .o_stuck (o_stuck),
        .o_drop  (o_drop)
    );

    typedef struct {
        int duty;
        int per;
        int stuck;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   drop_q[$];
    exp_t mon_e;
    int   mon_d;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    bit seek = 1'b1;
    bit pwm_lvl = 1'b0;
    int rise_r = 0;
    int busy_until = 0;
    int prev_duty = 0;
    int prev_per = 0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge i_clk) begin
        if (o_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected o_valid", int'(o_valid), 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("valid cycle", cyc, mon_e.cyc);
                chk("duty", int'(o_duty), mon_e.duty);
                chk("period", int'(o_period), mon_e.per);
                chk("stuck", int'(o_stuck), mon_e.stuck);
            end
        end
        if (o_drop) begin
            if (drop_q.size() == 0) begin
                chk("unexpected o_drop", int'(o_drop), 0);
            end else begin
                mon_d = drop_q.pop_front();
                chk("drop cycle", cyc, mon_d);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Drive the line; a change made in cycle k reaches s2 in cycle k+2.
    task automatic set_pwm(input bit v);
        int r;
        i_pwm = v;
        r = cyc + 2;
        if (v && !pwm_lvl && i_en) begin
            if (!seek) begin
                if (r <= busy_until) begin
                    drop_q.push_back(r + 1);
                end else begin
                    exp_q.push_back('{prev_duty, prev_per, 0, r + 8});
                    busy_until = r + 7;
                end
            end
            seek = 1'b0;
            rise_r = r;
        end
        pwm_lvl = v;
    endtask

    task automatic wave(input int hi, input int lo, input int n, input int duty);
        if (pwm_lvl) begin
            set_pwm(1'b0);
            step(10);
        end
        for (int i = 0; i < n; i++) begin
            set_pwm(1'b1);
            prev_duty = duty;
            prev_per = hi + lo;
            step(hi);
            set_pwm(1'b0);
            step(lo);
        end
    endtask

    initial begin
        i_rst = 1'b1;
        i_en = 1'b1;
        i_pwm = 1'b0;
        step(3);
        chk("reset duty", int'(o_duty), 0);
        chk("reset period", int'(o_period), 0);
        chk("reset stuck", int'(o_stuck), 0);
        chk("reset valid", int'(o_valid), 0);
        chk("reset drop", int'(o_drop), 0);
        i_rst = 1'b0;
        step(5);

        wave(2500, 2500, 2, 64);
        wave(1000, 4000, 1, 25);
        wave(1, 4999, 1, 0);
        wave(4999, 1, 1, 127);

        // stuck high after a valid measurement
        set_pwm(1'b1);
        exp_q.push_back('{127, 0, 1, rise_r + 8000});
        step(8020);
        seek = 1'b1;
        busy_until = 0;

        wave(2500, 2500, 2, 64);

        // stuck low
        exp_q.push_back('{0, 0, 1, rise_r + 8000});
        while (cyc < rise_r + 8010) step(1);
        seek = 1'b1;
        busy_until = 0;

        wave(2, 2, 8, 64);

        // enable dropped in the middle of a high phase
        set_pwm(1'b1);
        step(40);
        i_en = 1'b0;
        seek = 1'b1;
        busy_until = 0;
        step(10);
        set_pwm(1'b0);
        step(10);
        set_pwm(1'b1);
        step(10);
        chk("hold duty", int'(o_duty), 64);
        chk("hold period", int'(o_period), 4);
        chk("hold stuck", int'(o_stuck), 0);
        step(10);
        i_en = 1'b1;
        step(30);
        wave(2500, 2500, 2, 64);

        // reset three cycles into a division
        wave(3, 5, 1, 48);
        set_pwm(1'b1);
        step(3);
        set_pwm(1'b0);
        step(2);
        i_rst = 1'b1;
        step(1);
        i_rst = 1'b0;
        void'(exp_q.pop_back());
        seek = 1'b1;
        busy_until = 0;
        chk("post-reset duty", int'(o_duty), 0);
        chk("post-reset period", int'(o_period), 0);
        chk("post-reset stuck", int'(o_stuck), 0);
        chk("post-reset valid", int'(o_valid), 0);
        step(20);
        wave(2500, 2500, 2, 64);
        step(20);

        chk("pending valids", exp_q.size(), 0);
        chk("pending drops", drop_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
